// File: rtl/dqs_eye_train_ctrl_if.sv
// Bus bundle between the DQS eye-training controller, the PHY training
// sequencer and one DQS lane IOD.
// The debug counters exist only when DQS_EYE_TRAIN_DBG_EN is defined.
interface dqs_eye_train_ctrl_if #(
    parameter int TAP_W = 7,
    parameter int CNT_W = 5
);
    // Sequencer request side
    logic             start;
    logic             abort;
    // IOD status flags
    logic             eye_monitor_early;
    logic             eye_monitor_late;
    logic             delay_line_out_of_range;
    // IOD control pulses
    logic             delay_line_load;
    logic             delay_line_move;
    logic             delay_line_direction;
    logic             eye_monitor_clear_flags;
    // Sequencer status side
    logic             train_busy;
    logic             train_done;
    logic             train_fail;
    logic [TAP_W-1:0] tap_count;
`ifdef DQS_EYE_TRAIN_DBG_EN
    logic [CNT_W-1:0] dbg_early_cnt;
    logic [CNT_W-1:0] dbg_late_cnt;
    logic [7:0]       dbg_step_cnt;
`endif

`ifdef DQS_EYE_TRAIN_DBG_EN
    modport master (
        input  start, abort, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        output train_busy, train_done, train_fail, tap_count,
        output dbg_early_cnt, dbg_late_cnt, dbg_step_cnt
    );
    modport slave (
        output start, abort, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        input  train_busy, train_done, train_fail, tap_count,
        input  dbg_early_cnt, dbg_late_cnt, dbg_step_cnt
    );
`else
    modport master (
        input  start, abort, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        output delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        output train_busy, train_done, train_fail, tap_count
    );
    modport slave (
        output start, abort, eye_monitor_early, eye_monitor_late, delay_line_out_of_range,
        input  delay_line_load, delay_line_move, delay_line_direction, eye_monitor_clear_flags,
        input  train_busy, train_done, train_fail, tap_count
    );
`endif
endinterface

// File: rtl/dqs_eye_train_ctrl.sv
// DQS read-eye centring controller for one IOD lane.
// Loads the static delay, then repeatedly clears the eye flags, integrates
// early/late over a fixed window and steps the delay line toward balance
// until LOCK_WINDOWS consecutive balanced windows are seen.
// Optional feature macro: DQS_EYE_TRAIN_DBG_EN adds last-window early/late
// counts and the step count as debug outputs.
module dqs_eye_train_ctrl #(
    parameter int TAP_W         = 7,
    parameter int MAX_TAPS      = 127,
    parameter int SETTLE_CYCLES = 8,
    parameter int SAMPLE_CYCLES = 16,
    parameter int LOCK_WINDOWS  = 3,
    parameter int MAX_STEPS     = 255
) (
    input  logic              fab_clk,
    input  logic              arst_n,
    dqs_eye_train_ctrl_if.master bus
);

    localparam int CNT_W  = $clog2(SAMPLE_CYCLES + 1);
    localparam int SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST   = LOCK_W'(LOCK_WINDOWS - 1);
    localparam logic [STEP_W-1:0] STEP_LIMIT  = STEP_W'(MAX_STEPS);
    localparam logic [TAP_W-1:0]  TAP_TOP     = TAP_W'(MAX_TAPS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_CLEAR,
        S_SETTLE2,
        S_SAMPLE,
        S_DECIDE,
        S_MOVE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t            state;
    logic [SET_W-1:0]  settle_cnt;
    logic [CNT_W-1:0]  sample_cnt;
    logic [CNT_W-1:0]  early_cnt;
    logic [CNT_W-1:0]  late_cnt;
    logic [LOCK_W-1:0] lock_cnt;
    logic [STEP_W-1:0] step_cnt;
    logic [TAP_W-1:0]  tap_q;
    logic              load_q;
    logic              move_q;
    logic              clear_q;
    logic              dir_q;
    logic              busy_q;
    logic              done_q;
    logic              fail_q;

    // Flag integration never exceeds the window length, but the counter is
    // still pinned at its top value rather than allowed to wrap.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic flag);
        if (flag && (cnt != {CNT_W{1'b1}})) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    // Training sequencer: state, counters and all registered outputs.
    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            sample_cnt <= '0;
            early_cnt  <= '0;
            late_cnt   <= '0;
            lock_cnt   <= '0;
            step_cnt   <= '0;
            tap_q      <= '0;
            load_q     <= 1'b0;
            move_q     <= 1'b0;
            clear_q    <= 1'b0;
            dir_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            // IOD strobes are single-cycle unless a transition re-arms one
            load_q  <= 1'b0;
            move_q  <= 1'b0;
            clear_q <= 1'b0;
            if (bus.abort) begin
                // Abort wins over everything; the tap offset is kept for inspection
                state  <= S_IDLE;
                busy_q <= 1'b0;
                done_q <= 1'b0;
                fail_q <= 1'b0;
            end else if (busy_q && bus.delay_line_out_of_range) begin
                // Delay line hit its physical limit: stop with the tap frozen
                state  <= S_FAIL;
                busy_q <= 1'b0;
                fail_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_DONE, S_FAIL: begin
                        if (bus.start) begin
                            state    <= S_LOAD;
                            load_q   <= 1'b1;
                            busy_q   <= 1'b1;
                            done_q   <= 1'b0;
                            fail_q   <= 1'b0;
                            tap_q    <= '0;
                            step_cnt <= '0;
                            lock_cnt <= '0;
                        end
                    end
                    S_LOAD: begin
                        tap_q      <= '0;
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            state   <= S_CLEAR;
                            clear_q <= 1'b1;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                    S_CLEAR: begin
                        early_cnt  <= '0;
                        late_cnt   <= '0;
                        settle_cnt <= '0;
                        state      <= S_SETTLE2;
                    end
                    S_SETTLE2: begin
                        if (settle_cnt == SETTLE_LAST) begin
                            sample_cnt <= '0;
                            state      <= S_SAMPLE;
                        end else begin
                            settle_cnt <= settle_cnt + SET_W'(1);
                        end
                    end
                    S_SAMPLE: begin
                        early_cnt <= sat_inc(early_cnt, bus.eye_monitor_early);
                        late_cnt  <= sat_inc(late_cnt, bus.eye_monitor_late);
                        if (sample_cnt == SAMPLE_LAST) begin
                            state <= S_DECIDE;
                        end else begin
                            sample_cnt <= sample_cnt + CNT_W'(1);
                        end
                    end
                    S_DECIDE: begin
                        if (early_cnt == late_cnt) begin
                            // Balanced window: count toward lock, no delay change
                            lock_cnt <= lock_cnt + LOCK_W'(1);
                            if (lock_cnt == LOCK_LAST) begin
                                state  <= S_DONE;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                            end else begin
                                state   <= S_CLEAR;
                                clear_q <= 1'b1;
                            end
                        end else begin
                            // Early dominates -> sampling too soon -> add delay
                            lock_cnt <= '0;
                            dir_q    <= (early_cnt > late_cnt);
                            if (((early_cnt > late_cnt) && (tap_q == TAP_TOP)) ||
                                ((early_cnt < late_cnt) && (tap_q == '0)) ||
                                (step_cnt == STEP_LIMIT)) begin
                                state  <= S_FAIL;
                                busy_q <= 1'b0;
                                fail_q <= 1'b1;
                            end else begin
                                state  <= S_MOVE;
                                move_q <= 1'b1;
                            end
                        end
                    end
                    S_MOVE: begin
                        tap_q      <= dir_q ? (tap_q + TAP_W'(1)) : (tap_q - TAP_W'(1));
                        step_cnt   <= step_cnt + STEP_W'(1);
                        settle_cnt <= '0;
                        state      <= S_SETTLE;
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.delay_line_load         = load_q;
    assign bus.delay_line_move         = move_q;
    assign bus.delay_line_direction    = dir_q;
    assign bus.eye_monitor_clear_flags = clear_q;
    assign bus.train_busy              = busy_q;
    assign bus.train_done              = done_q;
    assign bus.train_fail              = fail_q;
    assign bus.tap_count               = tap_q;

`ifdef DQS_EYE_TRAIN_DBG_EN
    logic [CNT_W-1:0] dbg_early_q;
    logic [CNT_W-1:0] dbg_late_q;
    logic [7:0]       dbg_step_q;

    // Debug snapshot of the window just judged, plus the running step count
    always_ff @(posedge fab_clk or negedge arst_n) begin
        if (!arst_n) begin
            dbg_early_q <= '0;
            dbg_late_q  <= '0;
            dbg_step_q  <= '0;
        end else begin
            if (state == S_DECIDE) begin
                dbg_early_q <= early_cnt;
                dbg_late_q  <= late_cnt;
            end
            dbg_step_q <= 8'(step_cnt);
        end
    end

    assign bus.dbg_early_cnt = dbg_early_q;
    assign bus.dbg_late_cnt  = dbg_late_q;
    assign bus.dbg_step_cnt  = dbg_step_q;
`else
    // Debug observation registers are not built in this configuration.
`endif

endmodule

// File: tb/tb_dqs_eye_train_ctrl.sv
// Self-checking bench for dqs_eye_train_ctrl: a table of training scenarios
// is replayed window by window, with expected MOVE directions and tap values
// queued as each window's flags are driven and popped on each MOVE pulse.
module tb_dqs_eye_train_ctrl;

    logic clk    = 1'b0;
    logic arst_n = 1'b0;

    bit st0  = 1'b0;
    bit ab0  = 1'b0;
    bit oor0 = 1'b0;
    bit st1  = 1'b0;
    bit e_in = 1'b0;
    bit l_in = 1'b0;

    int tests  = 0;
    int failed = 0;

    dqs_eye_train_ctrl_if #(.TAP_W(7), .CNT_W(5)) bus0 ();
    dqs_eye_train_ctrl_if #(.TAP_W(7), .CNT_W(5)) bus1 ();

    assign bus0.start                   = st0;
    assign bus0.abort                   = ab0;
    assign bus0.eye_monitor_early       = e_in;
    assign bus0.eye_monitor_late        = l_in;
    assign bus0.delay_line_out_of_range = oor0;
    assign bus1.start                   = st1;
    assign bus1.abort                   = 1'b0;
    assign bus1.eye_monitor_early       = e_in;
    assign bus1.eye_monitor_late        = l_in;
    assign bus1.delay_line_out_of_range = 1'b0;

    dqs_eye_train_ctrl #(.MAX_STEPS(255)) u_dut (
        .fab_clk (clk),
        .arst_n  (arst_n),
        .bus     (bus0.master)
    );

    dqs_eye_train_ctrl #(.MAX_STEPS(4)) u_dut4 (
        .fab_clk (clk),
        .arst_n  (arst_n),
        .bus     (bus1.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    dut;       // 0: MAX_STEPS=255, 1: MAX_STEPS=4
        int    pat;       // 0 quiet, 1 early for n windows, 2 late always, 3 early/late alternating
        int    n;
        int    oor_win;   // window in which OUT_OF_RANGE pulses mid-sample, -1 none
        int    ab_win;    // window whose DECIDE cycle sees ABORT, -1 none
        int    exp_moves;
        int    exp_done;
        int    exp_fail;
        int    exp_tap;
    } vec_t;

    typedef struct {
        bit dir;
        int tap;
    } sb_t;

    typedef struct {
        bit load;
        bit move;
        bit dir;
        bit clr;
        bit busy;
        bit done;
        bit fail;
        int tap;
    } outs_t;

    sb_t  sb[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic outs_t get_outs(input int sel);
        outs_t o;
        if (sel == 0) begin
            o.load = bus0.delay_line_load;  o.move = bus0.delay_line_move;
            o.dir  = bus0.delay_line_direction; o.clr = bus0.eye_monitor_clear_flags;
            o.busy = bus0.train_busy; o.done = bus0.train_done; o.fail = bus0.train_fail;
            o.tap  = int'(bus0.tap_count);
        end else begin
            o.load = bus1.delay_line_load;  o.move = bus1.delay_line_move;
            o.dir  = bus1.delay_line_direction; o.clr = bus1.eye_monitor_clear_flags;
            o.busy = bus1.train_busy; o.done = bus1.train_done; o.fail = bus1.train_fail;
            o.tap  = int'(bus1.tap_count);
        end
        return o;
    endfunction

    task automatic win_flags(input int pat, input int n, input int w, output bit e, output bit l);
        e = 1'b0;
        l = 1'b0;
        case (pat)
            1: e = (w < n);
            2: l = 1'b1;
            3: begin e = (w % 2 == 0); l = (w % 2 == 1); end
            default: ;
        endcase
    endtask

    task automatic run_vec(input vec_t v);
        outs_t o;
        sb_t   ex;
        int    win = -1, since = 0, moves = 0, excl = 0, ptap = 0, after_ab = 0;
        int    mtap = 0, msteps = 0, max_steps;
        bit    pend = 0, aborted = 0, oor_chk = 0, fin = 0, e, l;
        max_steps = (v.dut == 0) ? 255 : 4;
        sb.delete();
        @(negedge clk);
        if (v.dut == 0) st0 = 1'b1; else st1 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        st1 = 1'b0;
        o = get_outs(v.dut);
        check({v.name, "_load_pulse"}, int'(o.load), 1);
        check({v.name, "_busy_start"}, int'(o.busy), 1);
        check({v.name, "_status_cleared"}, int'(o.done | o.fail), 0);
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            @(negedge clk);
            o = get_outs(v.dut);
            since++;
            if (int'(o.load) + int'(o.move) + int'(o.clr) > 1) excl++;
            if (pend) begin
                check({v.name, "_tap_after_move"}, o.tap, ptap);
                pend = 0;
            end
            if (o.move) begin
                moves++;
                if (sb.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL %s_unexpected_move: got move %0d, expected none", v.name, moves);
                end else begin
                    ex = sb.pop_front();
                    check({v.name, "_move_dir"}, int'(o.dir), int'(ex.dir));
                    pend = 1;
                    ptap = ex.tap;
                end
            end
            if (oor_chk) begin
                check({v.name, "_oor_fail_next"}, int'(o.fail), 1);
                check({v.name, "_oor_busy_low"}, int'(o.busy), 0);
                oor0 = 1'b0;
                oor_chk = 0;
            end
            if (aborted) begin
                after_ab++;
                if (after_ab == 1) begin
                    ab0 = 1'b0;
                    check({v.name, "_abort_no_move"}, int'(o.move), 0);
                    check({v.name, "_abort_idle"}, int'(o.busy), 0);
                end
                if (after_ab >= 4) fin = 1;
            end else if (o.done || o.fail) begin
                fin = 1;
            end
            if (o.clr && !fin) begin
                win++;
                since = 0;
                win_flags(v.pat, v.n, win, e, l);
                e_in = e;
                l_in = l;
                if (e != l) begin
                    if (!((e && mtap == 127) || (!e && mtap == 0) || msteps == max_steps)) begin
                        mtap = e ? mtap + 1 : mtap - 1;
                        msteps++;
                        ex.dir = e;
                        ex.tap = mtap;
                        sb.push_back(ex);
                    end
                end
            end
            if (!fin && win == v.oor_win && since == 10) begin
                oor0 = 1'b1;
                oor_chk = 1;
            end
            if (!fin && !aborted && win == v.ab_win && since == 25) begin
                ab0 = 1'b1;
                aborted = 1;
                sb.delete();
            end
        end
        if (!fin) begin
            tests++;
            failed++;
            $display("FAIL %s_timeout: got no DONE/FAIL/abort end, expected completion", v.name);
        end
        ab0 = 1'b0;
        oor0 = 1'b0;
        e_in = 1'b0;
        l_in = 1'b0;
        o = get_outs(v.dut);
        check({v.name, "_done"}, int'(o.done), v.exp_done);
        check({v.name, "_fail"}, int'(o.fail), v.exp_fail);
        check({v.name, "_busy_end"}, int'(o.busy), 0);
        check({v.name, "_tap_end"}, o.tap, v.exp_tap);
        check({v.name, "_move_count"}, moves, v.exp_moves);
        check({v.name, "_sb_drained"}, sb.size(), 0);
        check({v.name, "_pulse_exclusive"}, excl, 0);
    endtask

    initial begin
        outs_t o;
        bit    seen;
        vecs[0] = '{"quiet",      0, 0, 0, -1, -1, 0, 1, 0, 0};
        vecs[1] = '{"early5",     0, 1, 5, -1, -1, 5, 1, 0, 5};
        vecs[2] = '{"late_at0",   0, 2, 0, -1, -1, 0, 0, 1, 0};
        vecs[3] = '{"early2",     0, 1, 2, -1, -1, 2, 1, 0, 2};
        vecs[4] = '{"oor_tap3",   0, 1, 3,  3, -1, 3, 0, 1, 3};
        vecs[5] = '{"abort_move", 0, 1, 1, -1,  0, 0, 0, 0, 0};
        vecs[6] = '{"alt_steps4", 1, 3, 0, -1, -1, 4, 0, 1, 0};

        // Reset state
        repeat (3) @(negedge clk);
        o = get_outs(0);
        check("rst_load", int'(o.load), 0);
        check("rst_move", int'(o.move), 0);
        check("rst_dir", int'(o.dir), 0);
        check("rst_clear", int'(o.clr), 0);
        check("rst_busy", int'(o.busy), 0);
        check("rst_done", int'(o.done), 0);
        check("rst_fail", int'(o.fail), 0);
        check("rst_tap", o.tap, 0);
        arst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // START together with ABORT in IDLE must not start training
        @(negedge clk);
        st0 = 1'b1;
        ab0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        ab0 = 1'b0;
        o = get_outs(0);
        check("start_abort_busy", int'(o.busy), 0);
        check("start_abort_load", int'(o.load), 0);
        @(negedge clk);
        o = get_outs(0);
        check("start_abort_still_idle", int'(o.busy), 0);

        // START while busy is ignored; reset mid-SAMPLE clears outputs at once
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        repeat (3) @(negedge clk);
        st0 = 1'b1;
        @(negedge clk);
        st0 = 1'b0;
        o = get_outs(0);
        check("busy_start_no_load", int'(o.load), 0);
        seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = bus0.eye_monitor_clear_flags;
        end
        check("first_clear_seen", int'(seen), 1);
        repeat (12) @(negedge clk);
        o = get_outs(0);
        check("pre_reset_busy", int'(o.busy), 1);
        arst_n = 1'b0;
        #1;
        o = get_outs(0);
        check("midrst_busy", int'(o.busy), 0);
        check("midrst_pulses", int'(o.load | o.move | o.clr), 0);
        check("midrst_status", int'(o.done | o.fail | o.dir), 0);
        check("midrst_tap", o.tap, 0);
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
